// File: rtl/operand_capture_ctrl_if.sv
// Operand-capture bundle between the press/switch/core side and the capture controller.
// Latency: none, wires only.
// Backpressure: none; the controller drops presses it cannot take.
interface operand_capture_ctrl_if #(
    parameter int DW = 8
);
    logic              one_shot;
    logic [DW-1:0]     switches;
    logic              done;
    logic [2*DW-1:0]   product;
    logic [DW-1:0]     multiplicand;
    logic [DW-1:0]     multiplier;
    logic              start;
    logic [2*DW-1:0]   result;
    logic              busy;
    logic              result_valid;
    logic              error;

    // Board/core side: drives press, switches and core completion.
    modport master (
        output one_shot, switches, done, product,
        input  multiplicand, multiplier, start, result, busy, result_valid, error
    );

    // Controller side.
    modport slave (
        input  one_shot, switches, done, product,
        output multiplicand, multiplier, start, result, busy, result_valid, error
    );
endinterface

// File: rtl/operand_capture_ctrl.sv
// Latches two operands on successive presses, kicks the multiplier core, holds its product.
// Latency: operands/start/status appear the cycle after the sampling edge; all outputs registered.
// Backpressure: presses in START/WAIT_DONE are dropped; done is ignored outside WAIT_DONE.
module operand_capture_ctrl #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    operand_capture_ctrl_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        CAP_A,
        CAP_B,
        START,
        WAIT_DONE,
        SHOW,
        ERR
    } state_t;

    state_t          state;
    logic [CW-1:0]   wd_cnt;

    // Status outputs are updated alongside each transition so they always
    // match the state being entered, without any combinational input path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= CAP_A;
            wd_cnt           <= '0;
            bus.multiplicand <= '0;
            bus.multiplier   <= '0;
            bus.result       <= '0;
            bus.start        <= 1'b0;
            bus.busy         <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.error        <= 1'b0;
        end else begin
            case (state)
                CAP_A: begin
                    if (bus.one_shot) begin
                        bus.multiplicand <= bus.switches;
                        state            <= CAP_B;
                    end
                end
                CAP_B: begin
                    if (bus.one_shot) begin
                        bus.multiplier <= bus.switches;
                        state          <= START;
                        bus.start      <= 1'b1;
                        bus.busy       <= 1'b1;
                    end
                end
                START: begin
                    state     <= WAIT_DONE;
                    bus.start <= 1'b0;
                    wd_cnt    <= '0;
                end
                WAIT_DONE: begin
                    // done beats the watchdog when both land on the same edge
                    if (bus.done) begin
                        bus.result       <= bus.product;
                        bus.result_valid <= 1'b1;
                        bus.busy         <= 1'b0;
                        state            <= SHOW;
                    end else if (wd_cnt == WD_LAST) begin
                        bus.error <= 1'b1;
                        bus.busy  <= 1'b0;
                        state     <= ERR;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                SHOW: begin
                    if (bus.one_shot) begin
                        bus.result_valid <= 1'b0;
                        state            <= CAP_A;
                    end
                end
                ERR: begin
                    if (bus.one_shot) begin
                        bus.error <= 1'b0;
                        state     <= CAP_A;
                    end
                end
                default: begin
                    state            <= CAP_A;
                    bus.start        <= 1'b0;
                    bus.busy         <= 1'b0;
                    bus.result_valid <= 1'b0;
                    bus.error        <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_operand_capture_ctrl.sv
// Scoreboard bench for operand_capture_ctrl: stimulus queues expected start/result/error
// events with their cycle; a monitor pops and checks them as the DUT raises each output.
module tb_operand_capture_ctrl;
    localparam int DW = 8;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        int          kind;   // 0 start, 1 result, 2 error
        int          cyc;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
    } exp_t;

    exp_t        q[$];
    logic [15:0] exp_result = 16'h0;

    operand_capture_ctrl_if #(.DW(DW)) bus ();

    operand_capture_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ev(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
        end else begin
            e = q.pop_front();
            chk("ev_kind", kind, e.kind);
            chk("ev_cycle", cyc, e.cyc);
            chk("ev_multiplicand", {24'h0, bus.multiplicand}, {24'h0, e.a});
            chk("ev_multiplier", {24'h0, bus.multiplier}, {24'h0, e.b});
            chk("ev_result", {16'h0, bus.result}, {16'h0, e.res});
            chk("ev_busy", {31'h0, bus.busy}, (e.kind == 0) ? 32'd1 : 32'd0);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        logic prev_start = 1'b0;
        logic prev_rv    = 1'b0;
        logic prev_err   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (prev_start) chk("start_width", {31'h0, bus.start}, 32'd0);
            if (bus.start === 1'b1 && !prev_start) ev(0);
            if (bus.result_valid === 1'b1 && !prev_rv) ev(1);
            if (bus.error === 1'b1 && !prev_err) ev(2);
            prev_start = (bus.start === 1'b1);
            prev_rv    = (bus.result_valid === 1'b1);
            prev_err   = (bus.error === 1'b1);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] v);
        bus.switches = v;
        bus.one_shot = 1'b1;
        @(negedge clk);
        bus.one_shot = 1'b0;
    endtask

    task automatic push(input int kind, input int c, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] res);
        exp_t e;
        e.kind = kind; e.cyc = c; e.a = a; e.b = b; e.res = res;
        q.push_back(e);
    endtask

    // Full operation; delay < 0 means the core never answers.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input int delay, input logic [15:0] prod);
        int s;
        press(a);
        s = cyc + 1;
        push(0, s, a, b, exp_result);
        if (delay < 0) push(2, s + TIMEOUT + 1, a, b, exp_result);
        press(b);
        if (delay >= 0) begin
            tick(delay);
            push(1, cyc + 1, a, b, prod);
            bus.done    = 1'b1;
            bus.product = prod;
            @(negedge clk);
            bus.done    = 1'b0;
            exp_result  = prod;
            tick(2);
        end else begin
            tick(TIMEOUT + 6);
        end
    endtask

    task automatic check_idle(input string tag, input logic [15:0] res);
        chk({tag, "_start"}, {31'h0, bus.start}, 32'd0);
        chk({tag, "_busy"}, {31'h0, bus.busy}, 32'd0);
        chk({tag, "_result_valid"}, {31'h0, bus.result_valid}, 32'd0);
        chk({tag, "_error"}, {31'h0, bus.error}, 32'd0);
        chk({tag, "_result"}, {16'h0, bus.result}, {16'h0, res});
    endtask

    initial begin
        int s;
        bus.one_shot = 1'b0;
        bus.switches = '0;
        bus.done     = 1'b0;
        bus.product  = '0;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        check_idle("rst", 16'h0);
        chk("rst_multiplicand", {24'h0, bus.multiplicand}, 32'd0);
        chk("rst_multiplier", {24'h0, bus.multiplier}, 32'd0);

        // Basic multiply: 12 x 11, done ten cycles after start
        run_op(8'd12, 8'd11, 10, 16'd132);
        chk("basic_result_valid", {31'h0, bus.result_valid}, 32'd1);
        press(8'd0);
        tick(1);
        check_idle("show_exit", 16'd132);

        // Timeout: no done; error after TIMEOUT edges in WAIT_DONE
        run_op(8'd12, 8'd11, -1, 16'h0);
        chk("timeout_error_held", {31'h0, bus.error}, 32'd1);
        press(8'd0);
        tick(1);
        check_idle("err_exit", 16'd132);

        // Boundary: done on the edge where the watchdog is at TIMEOUT-1
        run_op(8'd5, 8'd7, TIMEOUT, 16'd35);
        chk("boundary_no_error", {31'h0, bus.error}, 32'd0);
        chk("boundary_show", {31'h0, bus.result_valid}, 32'd1);
        press(8'd0);
        tick(1);

        // Dropped presses and spurious done in CAP_B
        press(8'd3);
        bus.done = 1'b1; bus.product = 16'hDEAD;
        @(negedge clk);
        bus.done = 1'b0;
        tick(1);
        chk("spurious_done_result", {16'h0, bus.result}, 32'd35);
        chk("spurious_done_rv", {31'h0, bus.result_valid}, 32'd0);
        chk("spurious_done_a", {24'h0, bus.multiplicand}, 32'd3);
        s = cyc + 1;
        push(0, s, 8'd3, 8'd4, exp_result);
        press(8'd4);
        tick(2);
        press(8'h77);
        press(8'h55);
        tick(1);
        chk("dropped_busy", {31'h0, bus.busy}, 32'd1);
        push(1, cyc + 1, 8'd3, 8'd4, 16'd12);
        bus.done = 1'b1; bus.product = 16'd12;
        bus.one_shot = 1'b1;
        @(negedge clk);
        bus.done = 1'b0; bus.one_shot = 1'b0;
        exp_result = 16'd12;
        tick(2);
        chk("dropped_still_show", {31'h0, bus.result_valid}, 32'd1);
        press(8'd0);
        tick(1);

        // Reset in WAIT_DONE, then a late done
        s = cyc + 2;
        press(8'd9);
        push(0, s, 8'd9, 8'd9, exp_result);
        press(8'd9);
        tick(5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.done = 1'b1; bus.product = 16'd81;
        @(negedge clk);
        bus.done = 1'b0;
        exp_result = 16'h0;
        tick(3);
        check_idle("mid_reset", 16'h0);
        chk("mid_reset_multiplicand", {24'h0, bus.multiplicand}, 32'd0);
        chk("mid_reset_multiplier", {24'h0, bus.multiplier}, 32'd0);

        // Wrap values: FF x FF, then leave SHOW
        run_op(8'hFF, 8'hFF, 3, 16'hFE01);
        press(8'h10);
        tick(1);
        check_idle("wrap_exit", 16'hFE01);
        press(8'h21);
        tick(1);
        chk("wrap_recapture_a", {24'h0, bus.multiplicand}, 32'h21);

        tick(4);
        chk("events_outstanding", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
